// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI memory responder definitions: burst/resp encodings and FSM state types.
package axi_mem_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // Only FIXED and INCR are served; WRAP and the reserved code answer SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == FIXED) || (burst == INCR);
  endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4 memory channel bundle; master drives requests, slave answers.
interface axi_mem_responder_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi_mem_responder_dpram.sv
// Simple dual-port word array: byte-masked write port, registered read port (1-cycle latency).
// A same-cycle read of the word being written returns the old contents.
module axi_mem_dpram #(
  parameter int AW = 13,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_dat,
  input  logic [DW/8-1:0] wr_strb,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_dat
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wr_strb[i]) mem[wr_addr][i*8 +: 8] <= wr_dat[i*8 +: 8];
      end
    end
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory: independent write/read FSMs, first R beat 2 cycles after AR, 2-entry R skid.
// Define AXI_MEM_STATS_EN to add saturating beat/error counters.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  axi_mem_responder_if.slave s
`ifdef AXI_MEM_STATS_EN
  ,
  output logic [31:0]        wr_beat_cnt,
  output logic [31:0]        rd_beat_cnt,
  output logic [15:0]        err_cnt
`endif
);

  localparam int OFFS = $clog2(STRB_WIDTH);
  localparam int WA   = ADDR_WIDTH - OFFS;

  // Size is always treated as full width and the byte offset is dropped.
  logic unused_ok;
  assign unused_ok = ^{s.awsize, s.arsize, s.awaddr[OFFS-1:0], s.araddr[OFFS-1:0]};

  // ---------------- write path ----------------
  wr_state_t             w_state;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [WA-1:0]         w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err, w_lastbad;
  logic                  w_hs, w_last, ram_we;

  assign w_hs   = wready_q && s.wvalid;
  assign w_last = (w_cnt == w_len);
  assign ram_we = w_hs && !w_err;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      bid_q     <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= INCR;
      w_err     <= 1'b0;
      w_lastbad <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && s.awvalid) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s.awid;
            w_addr    <= s.awaddr[ADDR_WIDTH-1:OFFS];
            w_len     <= s.awlen;
            w_cnt     <= '0;
            w_burst   <= s.awburst;
            w_err     <= !burst_ok(s.awburst);
            w_lastbad <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_burst == INCR) w_addr <= w_addr + WA'(1);
            if (s.wlast != w_last) w_lastbad <= 1'b1;
            if (w_last) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (w_err || w_lastbad || !s.wlast) ? SLVERR : OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_t             r_state;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [WA-1:0]         r_addr;
  logic [7:0]            r_len, r_iss_cnt;
  logic [1:0]            r_burst;
  logic                  r_err, r_iss_done, r_pend, r_pend_last;
  logic                  rvalid_q, rlast_q, sk_vld, sk_last;
  logic [DATA_WIDTH-1:0] rdata_q, sk_dat, ram_q, push_dat;
  logic [1:0]            rresp_q, sk_resp, push_resp;
  logic [1:0]            occ;
  logic                  r_pop, r_issue;

  // Reads are only issued when the head/skid pair can absorb everything in flight.
  assign r_pop     = rvalid_q && s.rready;
  assign occ       = 2'(rvalid_q) + 2'(sk_vld) + 2'(r_pend);
  assign r_issue   = (r_state == R_DATA) && !r_iss_done && ((occ - 2'(r_pop)) < 2'd2);
  assign push_dat  = r_err ? '0 : ram_q;
  assign push_resp = r_err ? SLVERR : OKAY;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= R_IDLE;
      arready_q   <= 1'b0;
      rid_q       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_iss_cnt   <= '0;
      r_burst     <= INCR;
      r_err       <= 1'b0;
      r_iss_done  <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
      rlast_q     <= 1'b0;
      sk_vld      <= 1'b0;
      sk_dat      <= '0;
      sk_resp     <= OKAY;
      sk_last     <= 1'b0;
    end else begin
      r_pend      <= r_issue;
      r_pend_last <= r_issue && (r_iss_cnt == r_len);
      if (r_issue) begin
        r_iss_cnt <= r_iss_cnt + 8'd1;
        if (r_burst == INCR) r_addr <= r_addr + WA'(1);
        if (r_iss_cnt == r_len) r_iss_done <= 1'b1;
      end

      if (r_pend) begin
        if (!rvalid_q || (r_pop && !sk_vld)) begin
          rvalid_q <= 1'b1;
          rdata_q  <= push_dat;
          rresp_q  <= push_resp;
          rlast_q  <= r_pend_last;
        end else if (r_pop) begin
          rdata_q  <= sk_dat;
          rresp_q  <= sk_resp;
          rlast_q  <= sk_last;
          sk_dat   <= push_dat;
          sk_resp  <= push_resp;
          sk_last  <= r_pend_last;
        end else begin
          sk_vld   <= 1'b1;
          sk_dat   <= push_dat;
          sk_resp  <= push_resp;
          sk_last  <= r_pend_last;
        end
      end else if (r_pop) begin
        if (sk_vld) begin
          rdata_q <= sk_dat;
          rresp_q <= sk_resp;
          rlast_q <= sk_last;
          sk_vld  <= 1'b0;
        end else begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
        end
      end

      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s.arvalid) begin
            arready_q  <= 1'b0;
            rid_q      <= s.arid;
            r_addr     <= s.araddr[ADDR_WIDTH-1:OFFS];
            r_len      <= s.arlen;
            r_iss_cnt  <= '0;
            r_burst    <= s.arburst;
            r_err      <= !burst_ok(s.arburst);
            r_iss_done <= 1'b0;
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_pop && rlast_q) begin
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
      endcase
    end
  end

  axi_mem_dpram #(.AW(WA), .DW(DATA_WIDTH)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (w_addr),
    .wr_dat  (s.wdata),
    .wr_strb (s.wstrb),
    .rd_en   (r_issue && !r_err),
    .rd_addr (r_addr),
    .rd_dat  (ram_q)
  );

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.bid     = bid_q;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rlast   = rlast_q;
  assign s.rid     = rid_q;

`ifdef AXI_MEM_STATS_EN
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = 2'(bvalid_q && s.bready && (bresp_q == SLVERR))
                 + 2'(r_pop && (rresp_q == SLVERR));
  assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      if (w_hs && (wr_beat_cnt != '1)) wr_beat_cnt <= wr_beat_cnt + 32'd1;
      if (r_pop && (rd_beat_cnt != '1)) rd_beat_cnt <= rd_beat_cnt + 32'd1;
      err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: handshakes, burst data, strobes, errors, wrap and reset.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s ();

`ifdef AXI_MEM_STATS_EN
  logic [31:0] wr_beat_cnt, rd_beat_cnt;
  logic [15:0] err_cnt;
`endif

  axi_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .s         (s)
`ifdef AXI_MEM_STATS_EN
    ,
    .wr_beat_cnt (wr_beat_cnt),
    .rd_beat_cnt (rd_beat_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] wbeat [16];
  logic [63:0] rbuf  [16];
  logic [1:0]  rrsp  [16];
  int          lat, nbeat, nlast, lastidx;
  logic [3:0]  rid_seen;
  logic [1:0]  bresp_got;
  logic [3:0]  bid_got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] strb, input bit bad_last, input logic [3:0] id,
                          output logic [1:0] resp, output logic [3:0] bid);
    int t;
    s.awid = id; s.awaddr = addr; s.awlen = len; s.awsize = 3'd3; s.awburst = burst;
    s.awvalid = 1'b1;
    t = 0;
    while (!s.awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_wait", 64'(t < 50), 64'd1);
    @(negedge clk);
    s.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s.wdata = wbeat[i]; s.wstrb = strb; s.wlast = (i == int'(len)) ^ bad_last;
      s.wvalid = 1'b1;
      t = 0;
      while (!s.wready && t < 50) begin @(negedge clk); t++; end
      chk("w_wait", 64'(t < 50), 64'd1);
      @(negedge clk);
    end
    s.wvalid = 1'b0; s.wlast = 1'b0; s.bready = 1'b1;
    t = 0;
    while (!s.bvalid && t < 50) begin @(negedge clk); t++; end
    chk("b_wait", 64'(t < 50), 64'd1);
    resp = s.bresp; bid = s.bid;
    @(negedge clk);
    s.bready = 1'b0;
    chk("awready_after_b", 64'(s.awready), 64'd1);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input bit toggle, input logic [3:0] id);
    int t;
    bit ph, stalled;
    logic [63:0] hold_d;
    logic hold_l;
    s.arid = id; s.araddr = addr; s.arlen = len; s.arsize = 3'd3; s.arburst = burst;
    s.arvalid = 1'b1; s.rready = 1'b0;
    t = 0;
    while (!s.arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_wait", 64'(t < 50), 64'd1);
    @(negedge clk);
    s.arvalid = 1'b0;
    lat = -1; nbeat = 0; nlast = 0; lastidx = -1; ph = 1'b1; stalled = 1'b0;
    hold_d = '0; hold_l = 1'b0; t = 0;
    while (nbeat <= int'(len) && t < 300) begin
      s.rready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (s.rvalid) begin
        if (lat < 0) lat = t;
        if (stalled) begin
          chk("r_hold_data", s.rdata, hold_d);
          chk("r_hold_last", 64'(s.rlast), 64'(hold_l));
        end
        if (s.rready) begin
          rbuf[nbeat] = s.rdata; rrsp[nbeat] = s.rresp; rid_seen = s.rid;
          if (s.rlast) begin nlast++; lastidx = nbeat; end
          nbeat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_d = s.rdata; hold_l = s.rlast;
        end
      end
      @(negedge clk);
      t++;
    end
    s.rready = 1'b0;
    chk("r_wait", 64'(t < 300), 64'd1);
    chk("arready_after_r", 64'(s.arready), 64'd1);
    chk("rvalid_after_r", 64'(s.rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    s.awid = '0; s.awaddr = '0; s.awlen = '0; s.awsize = '0; s.awburst = '0; s.awvalid = 1'b0;
    s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0; s.wvalid = 1'b0; s.bready = 1'b0;
    s.arid = '0; s.araddr = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0; s.arvalid = 1'b0;
    s.rready = 1'b0;

    // 1. reset values, then ready one cycle after release
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(s.awready), 64'd0);
    chk("rst_arready", 64'(s.arready), 64'd0);
    chk("rst_wready",  64'(s.wready),  64'd0);
    chk("rst_bvalid",  64'(s.bvalid),  64'd0);
    chk("rst_rvalid",  64'(s.rvalid),  64'd0);
    chk("rst_rlast",   64'(s.rlast),   64'd0);
    chk("rst_rdata",   s.rdata,        64'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", 64'(s.awready), 64'd1);
    chk("idle_arready", 64'(s.arready), 64'd1);

    // 2. INCR 4-beat write and readback
    for (int i = 0; i < 4; i++) wbeat[i] = 64'hA0 + 64'(i);
    do_write(16'h0100, 8'd3, INCR, 8'hFF, 1'b0, 4'h5, bresp_got, bid_got);
    chk("t2_bresp", 64'(bresp_got), 64'(OKAY));
    chk("t2_bid", 64'(bid_got), 64'h5);
    do_read(16'h0100, 8'd3, INCR, 1'b0, 4'h9);
    chk("t2_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rdata", rbuf[i], 64'hA0 + 64'(i));
      chk("t2_rresp", 64'(rrsp[i]), 64'(OKAY));
    end
    chk("t2_nlast", 64'(nlast), 64'd1);
    chk("t2_lastidx", 64'(lastidx), 64'd3);
    chk("t2_rid", 64'(rid_seen), 64'h9);

    // 3. byte strobe merge
    wbeat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(16'h0200, 8'd0, INCR, 8'hFF, 1'b0, 4'h1, bresp_got, bid_got);
    wbeat[0] = 64'h11;
    do_write(16'h0200, 8'd0, INCR, 8'h01, 1'b0, 4'h1, bresp_got, bid_got);
    do_read(16'h0200, 8'd0, INCR, 1'b0, 4'h2);
    chk("t3_strobe", rbuf[0], 64'hFFFF_FFFF_FFFF_FF11);

    // 4. 8-beat read with rready toggling
    for (int i = 0; i < 8; i++) wbeat[i] = 64'h3000 + 64'(i);
    do_write(16'h0300, 8'd7, INCR, 8'hFF, 1'b0, 4'h3, bresp_got, bid_got);
    do_read(16'h0300, 8'd7, INCR, 1'b1, 4'h4);
    chk("t4_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 8; i++) chk("t4_rdata", rbuf[i], 64'h3000 + 64'(i));
    chk("t4_nlast", 64'(nlast), 64'd1);
    chk("t4_lastidx", 64'(lastidx), 64'd7);

    // 5. WRAP bursts are rejected; wlast mismatch still writes
    wbeat[0] = 64'hDEAD_BEEF_0000_0001; wbeat[1] = 64'hDEAD_BEEF_0000_0002;
    do_write(16'h0100, 8'd1, WRAP, 8'hFF, 1'b0, 4'h6, bresp_got, bid_got);
    chk("t5_wrap_bresp", 64'(bresp_got), 64'(SLVERR));
    do_read(16'h0100, 8'd1, INCR, 1'b0, 4'h6);
    chk("t5_unchanged0", rbuf[0], 64'hA0);
    chk("t5_unchanged1", rbuf[1], 64'hA1);
    do_read(16'h0100, 8'd1, WRAP, 1'b0, 4'h7);
    for (int i = 0; i < 2; i++) begin
      chk("t5_wrap_rdata", rbuf[i], 64'd0);
      chk("t5_wrap_rresp", 64'(rrsp[i]), 64'(SLVERR));
    end
    wbeat[0] = 64'h77; wbeat[1] = 64'h88;
    do_write(16'h0400, 8'd1, INCR, 8'hFF, 1'b1, 4'h8, bresp_got, bid_got);
    chk("t5_wlast_bresp", 64'(bresp_got), 64'(SLVERR));
    do_read(16'h0400, 8'd1, INCR, 1'b0, 4'h8);
    chk("t5_wlast_data0", rbuf[0], 64'h77);
    chk("t5_wlast_data1", rbuf[1], 64'h88);

    // FIXED burst and unaligned address
    wbeat[0] = 64'h1; wbeat[1] = 64'h2;
    do_write(16'h0500, 8'd1, FIXED, 8'hFF, 1'b0, 4'h2, bresp_got, bid_got);
    chk("fixed_bresp", 64'(bresp_got), 64'(OKAY));
    do_read(16'h0500, 8'd1, FIXED, 1'b0, 4'h2);
    chk("fixed_rd0", rbuf[0], 64'h2);
    chk("fixed_rd1", rbuf[1], 64'h2);
    do_read(16'h0103, 8'd0, INCR, 1'b0, 4'h2);
    chk("unaligned_rd", rbuf[0], 64'hA0);

    // 6. wrap at top of memory
    wbeat[0] = 64'h55; wbeat[1] = 64'h66;
    do_write(16'hFFF8, 8'd1, INCR, 8'hFF, 1'b0, 4'hA, bresp_got, bid_got);
    chk("t6_bresp", 64'(bresp_got), 64'(OKAY));
    do_read(16'h0000, 8'd0, INCR, 1'b0, 4'hB);
    chk("t6_word0", rbuf[0], 64'h66);
    do_read(16'hFFF8, 8'd1, INCR, 1'b0, 4'hB);
    chk("t6_top", rbuf[0], 64'h55);
    chk("t6_wrapped", rbuf[1], 64'h66);

    // reset in the middle of a read burst
    s.arid = 4'h3; s.araddr = 16'h0300; s.arlen = 8'd7; s.arsize = 3'd3; s.arburst = INCR;
    s.arvalid = 1'b1; s.rready = 1'b0;
    @(negedge clk);
    s.arvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_rvalid_before_rst", 64'(s.rvalid), 64'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", 64'(s.rvalid), 64'd0);
    chk("t6_rst_arready", 64'(s.arready), 64'd0);
    chk("t6_rst_rlast", 64'(s.rlast), 64'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("t6_arready_release", 64'(s.arready), 64'd1);
    do_read(16'h0300, 8'd1, INCR, 1'b0, 4'hC);
    chk("t6_post_rst_lat", 64'(lat), 64'd2);
    chk("t6_post_rst_d0", rbuf[0], 64'h3000);
    chk("t6_post_rst_d1", rbuf[1], 64'h3001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
